icache_fetch: RTL and testbench
===============================

// Module: icache_fetch
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the fetch stage and MemAdapter's
//  insfetch port. Hits return next cycle; misses drive try_start_insfetch_task/insfetch_addr,
//  wait for insfetch_task_done, fill the line, then respond. Handles pipeline flush mid-miss.
// PARAMETERS
//  INDEX_W   5   log2(line count); 32 lines of one 32-bit word each
//  ADDR_W   32   fetch address width; tag = addr[ADDR_W-1:INDEX_W+2]
// PORTS
//  clk_in                  in   1   system clock
//  rst_in                  in   1   asynchronous, active-low reset
//  rdy_in                  in   1   low = freeze all state (outputs hold)
//  flush_pipline           in   1   drop the in-flight fetch response
//  inv_all                 in   1   invalidate every line (fence.i)
//  req_valid               in   1   fetch stage presents req_addr
//  req_addr                in   32  fetch address; bits [1:0] ignored
//  req_ready               out  1   request accepted when req_valid && req_ready && rdy_in
//  resp_valid              out  1   one-cycle pulse: resp_ins valid for last accepted request
//  resp_ins                out  32  instruction word
//  try_start_insfetch_task out  1   miss fetch request to MemAdapter, held until done
//  insfetch_addr           out  32  word-aligned miss address
//  insfetch_task_done      in   1   MemAdapter completed fetch; insfetch_ins_full valid
//  insfetch_ins_full       in   32  fetched word
// BEHAVIOUR
//  Reset (rst_in=0, async): state=IDLE, all valid bits 0, req_ready=0 while in reset, resp_valid=0,
//   resp_ins=0, try_start_insfetch_task=0, insfetch_addr=0. Tag/data arrays not reset.
//  rdy_in=0: no state, array or output register changes; req_ready forced 0.
//  States: IDLE, MISS, DRAIN.
//  IDLE: req_ready=1. On accept: hit (valid[idx] && tag match) -> next cycle resp_valid=1,
//   resp_ins=data[idx], stay IDLE (back-to-back hits at 1/cycle). Miss -> latch addr, next cycle
//   try_start_insfetch_task=1, insfetch_addr={req_addr[31:2],2'b00}, go MISS.
//  MISS: req_ready=0; hold request stable. On insfetch_task_done: write tag/data, set valid,
//   deassert try_start same edge, next cycle resp_valid=1 with fetched word, go IDLE.
//   Miss latency = MemAdapter latency + 1 cycle.
//  DRAIN: entered from MISS on flush_pipline; MemAdapter task is never aborted: keep
//   try_start asserted until done, fill line, NO resp_valid, then IDLE.
//  flush_pipline in IDLE: kill any resp_valid due next cycle; a request in the same cycle is
//   not accepted (req_ready masked). Flush in the same cycle as done in MISS: fill, no response.
//  inv_all: clears all valid bits next edge; same-cycle fill is also invalidated (inv wins);
//   an in-flight miss still responds with its fetched word.
//  flush_pipline has priority over new requests; done before try_start is ignored.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs stat_hits[31:0], stat_misses[31:0]; counters wrap at
//   2^32, cleared by reset only, count accepted requests (flushed ones included).
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package/include: state encoding (IDLE/MISS/DRAIN), ICACHE_INDEX_W default.
//  One sub-module: icache_array (tag/valid/data storage, comb read, sync write, bulk invalidate).
// TESTING
//  Cold miss: req 0x0000_1000 -> try_start with insfetch_addr=0x1000; done with 0x0000_0013 ->
//   resp_valid next cycle, resp_ins=0x0000_0013.
//  Hit: re-request 0x1000 -> resp_valid next cycle, no try_start asserted.
//  Conflict: 0x1000 then 0x1080 (same idx, INDEX_W=5) -> both miss; 0x1000 again misses.
//  Flush mid-miss: flush while in MISS, done 3 cycles later -> no resp_valid; line filled, next
//   req 0x1000 hits.
//  rdy_in=0 for 4 cycles during MISS with done asserted -> no state change; completes after rdy.
//  inv_all after fills -> next req 0x1000 misses; async reset mid-MISS -> all outputs 0 at once.

Source files
------------

// File: rtl/icache_fetch_pkg.sv
// Shared definitions for the instruction cache: controller states and default geometry.
// Optional statistics counters are enabled by defining ICACHE_STATS_EN.
package icache_fetch_pkg;

    localparam int ICACHE_INDEX_W = 5;
    localparam int ICACHE_ADDR_W  = 32;
    localparam int ICACHE_WORD_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MISS  = 2'd1,
        ST_DRAIN = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_fetch_if.sv
// Fetch-stage request/response and MemAdapter insfetch signals of the instruction cache.
// master = fetch stage plus MemAdapter side, slave = the cache.
interface icache_fetch_if import icache_fetch_pkg::*; #(
    parameter int ADDR_W = ICACHE_ADDR_W
);
    logic                     req_valid;
    logic [ADDR_W-1:0]        req_addr;
    logic                     req_ready;
    logic                     resp_valid;
    logic [ICACHE_WORD_W-1:0] resp_ins;
    logic                     try_start_insfetch_task;
    logic [ADDR_W-1:0]        insfetch_addr;
    logic                     insfetch_task_done;
    logic [ICACHE_WORD_W-1:0] insfetch_ins_full;

    modport master (
        output req_valid, req_addr, insfetch_task_done, insfetch_ins_full,
        input  req_ready, resp_valid, resp_ins, try_start_insfetch_task, insfetch_addr
    );

    modport slave (
        input  req_valid, req_addr, insfetch_task_done, insfetch_ins_full,
        output req_ready, resp_valid, resp_ins, try_start_insfetch_task, insfetch_addr
    );
endinterface

// File: rtl/icache_fetch_array.sv
// Tag/valid/data storage for the direct-mapped cache: combinational read, synchronous write,
// single-cycle bulk invalidate that overrides a same-cycle fill.
module icache_array import icache_fetch_pkg::*; #(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = ICACHE_ADDR_W - ICACHE_INDEX_W - 2,
    parameter int WORD_W  = ICACHE_WORD_W
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               i_en,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [WORD_W-1:0]  o_rd_data,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [WORD_W-1:0]  i_wr_data,
    input  logic               i_inv_all
);
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [WORD_W-1:0] r_data [LINES];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= '0;
        end else if (i_en) begin
            if (i_inv_all) begin
                r_valid <= '0;
            end else if (i_wr_en) begin
                r_valid[i_wr_idx] <= 1'b1;
            end
        end
    end

    // Tag and data contents are meaningless until their valid bit is set.
    always_ff @(posedge clk_in) begin
        if (i_en && i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end
endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and MemAdapter insfetch.
// Define ICACHE_STATS_EN to add the stat_hits/stat_misses counter outputs.
module icache_fetch import icache_fetch_pkg::*; #(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int ADDR_W  = ICACHE_ADDR_W
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush_pipline,
    input  logic          inv_all,
    icache_fetch_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]   stat_hits,
    output logic [31:0]   stat_misses
`endif
);
    localparam int TAG_W  = ADDR_W - INDEX_W - 2;
    localparam int WORD_W = ICACHE_WORD_W;

    icache_state_e     r_state, w_state_nxt;
    logic              r_resp_valid, w_resp_valid_nxt;
    logic [WORD_W-1:0] r_resp_ins, w_resp_ins_nxt;
    logic              r_try_start, w_try_start_nxt;
    logic [ADDR_W-1:0] r_miss_addr, w_miss_addr_nxt;

    logic               w_req_ready, w_accept, w_hit, w_fill;
    logic [INDEX_W-1:0] w_req_idx, w_fill_idx;
    logic [TAG_W-1:0]   w_req_tag, w_fill_tag, w_rd_tag;
    logic               w_rd_valid;
    logic [WORD_W-1:0]  w_rd_data;
    logic               w_unused_addr_lsb;

    assign w_req_idx  = bus.req_addr[INDEX_W+1:2];
    assign w_req_tag  = bus.req_addr[ADDR_W-1:INDEX_W+2];
    assign w_fill_idx = r_miss_addr[INDEX_W+1:2];
    assign w_fill_tag = r_miss_addr[ADDR_W-1:INDEX_W+2];
    assign w_unused_addr_lsb = ^bus.req_addr[1:0];

    // Flush masks acceptance so a same-cycle request never produces a stale response.
    assign w_req_ready = rst_in && rdy_in && !flush_pipline && (r_state == ST_IDLE);
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_hit       = w_rd_valid && (w_rd_tag == w_req_tag);

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .WORD_W  (WORD_W)
    ) u_array (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_en       (rdy_in),
        .i_rd_idx   (w_req_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill),
        .i_wr_idx   (w_fill_idx),
        .i_wr_tag   (w_fill_tag),
        .i_wr_data  (bus.insfetch_ins_full),
        .i_inv_all  (inv_all)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_resp_valid_nxt = 1'b0;
        w_resp_ins_nxt   = r_resp_ins;
        w_try_start_nxt  = r_try_start;
        w_miss_addr_nxt  = r_miss_addr;
        w_fill           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_ins_nxt   = w_rd_data;
                    end else begin
                        w_state_nxt     = ST_MISS;
                        w_try_start_nxt = 1'b1;
                        w_miss_addr_nxt = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            ST_MISS: begin
                if (bus.insfetch_task_done) begin
                    w_fill          = 1'b1;
                    w_try_start_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                    if (!flush_pipline) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_ins_nxt   = bus.insfetch_ins_full;
                    end
                end else if (flush_pipline) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The MemAdapter task cannot be aborted; finish and fill silently.
                if (bus.insfetch_task_done) begin
                    w_fill          = 1'b1;
                    w_try_start_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_try_start_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_ins   <= '0;
            r_try_start  <= 1'b0;
            r_miss_addr  <= '0;
        end else if (rdy_in) begin
            r_state      <= w_state_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_ins   <= w_resp_ins_nxt;
            r_try_start  <= w_try_start_nxt;
            r_miss_addr  <= w_miss_addr_nxt;
        end
    end

    assign bus.req_ready               = w_req_ready;
    assign bus.resp_valid              = r_resp_valid;
    assign bus.resp_ins                = r_resp_ins;
    assign bus.try_start_insfetch_task = r_try_start;
    assign bus.insfetch_addr           = r_miss_addr;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_stat_hits, r_stat_misses;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end else begin
                r_stat_misses <= r_stat_misses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif
endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch with a line-level reference model checked every cycle.
module tb_icache_fetch;
    import icache_fetch_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic flush_pipline = 1'b0;
    logic inv_all = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    icache_fetch_if bus ();

    icache_fetch dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_pipline (flush_pipline),
        .inv_all       (inv_all),
        .bus           (bus)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: 32 lines, each remembering the full word address it holds.
    logic [31:0] m_valid;
    logic [31:0] m_line [32];
    logic [31:0] m_word [32];
    logic        m_busy, m_drop;
    logic        e_rv, e_try;
    logic [31:0] e_ins, e_addr;
    logic [31:0] m_hits, m_misses;

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd32);
    endfunction

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_valid  <= '0;
            m_busy   <= 1'b0;
            m_drop   <= 1'b0;
            e_rv     <= 1'b0;
            e_try    <= 1'b0;
            e_ins    <= '0;
            e_addr   <= '0;
            m_hits   <= '0;
            m_misses <= '0;
        end else if (rdy_in) begin
            e_rv <= 1'b0;
            if (m_busy) begin
                if (bus.insfetch_task_done) begin
                    m_line[line_of(e_addr)]  <= e_addr;
                    m_word[line_of(e_addr)]  <= bus.insfetch_ins_full;
                    m_valid[line_of(e_addr)] <= 1'b1;
                    m_busy <= 1'b0;
                    m_drop <= 1'b0;
                    e_try  <= 1'b0;
                    if (!m_drop && !flush_pipline) begin
                        e_rv  <= 1'b1;
                        e_ins <= bus.insfetch_ins_full;
                    end
                end else if (flush_pipline) begin
                    m_drop <= 1'b1;
                end
            end else if (bus.req_valid && !flush_pipline) begin
                if (m_valid[line_of(bus.req_addr)] &&
                    m_line[line_of(bus.req_addr)] == (bus.req_addr & ~32'd3)) begin
                    e_rv   <= 1'b1;
                    e_ins  <= m_word[line_of(bus.req_addr)];
                    m_hits <= m_hits + 32'd1;
                end else begin
                    m_busy   <= 1'b1;
                    e_try    <= 1'b1;
                    e_addr   <= bus.req_addr & ~32'd3;
                    m_misses <= m_misses + 32'd1;
                end
            end
            if (inv_all) m_valid <= '0;
        end
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
            chk("rst_resp_ins", bus.resp_ins, 32'd0);
            chk("rst_try_start", {31'd0, bus.try_start_insfetch_task}, 32'd0);
            chk("rst_insfetch_addr", bus.insfetch_addr, 32'd0);
        end else begin
            chk("req_ready", {31'd0, bus.req_ready}, {31'd0, rdy_in && !m_busy && !flush_pipline});
            chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, e_rv});
            if (e_rv) chk("resp_ins", bus.resp_ins, e_ins);
            chk("try_start", {31'd0, bus.try_start_insfetch_task}, {31'd0, e_try});
            if (e_try) chk("insfetch_addr", bus.insfetch_addr, e_addr);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic complete(input logic [31:0] w);
        bus.insfetch_task_done = 1'b1;
        bus.insfetch_ins_full  = w;
        tick();
        bus.insfetch_task_done = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic rv, input logic [31:0] ins, input logic tr);
        chk({nm, "_rv"}, {31'd0, bus.resp_valid}, {31'd0, rv});
        if (rv) chk({nm, "_ins"}, bus.resp_ins, ins);
        chk({nm, "_try"}, {31'd0, bus.try_start_insfetch_task}, {31'd0, tr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.insfetch_task_done = 1'b0;
        bus.insfetch_ins_full = '0;
        #1 rst_in = 1'b0;
        repeat (3) tick();
        chk("reset_ready", {31'd0, bus.req_ready}, 32'd0);
        chk_out("reset", 1'b0, 32'd0, 1'b0);
        rst_in = 1'b1;
        tick();
        chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);

        // Cold miss, MemAdapter latency of 3 cycles
        fetch(32'h0000_1000);
        chk("cold_try", {31'd0, bus.try_start_insfetch_task}, 32'd1);
        chk("cold_addr", bus.insfetch_addr, 32'h0000_1000);
        tick();
        tick();
        complete(32'h0000_0013);
        chk_out("cold_resp", 1'b1, 32'h0000_0013, 1'b0);
        tick();
        chk("cold_pulse", {31'd0, bus.resp_valid}, 32'd0);

        fetch(32'h0000_1000);
        chk_out("hit", 1'b1, 32'h0000_0013, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_1003;
        tick();
        chk_out("b2b_hit0", 1'b1, 32'h0000_0013, 1'b0);
        tick();
        chk_out("b2b_hit1", 1'b1, 32'h0000_0013, 1'b0);
        bus.req_valid = 1'b0;

        // Conflict on index 0
        fetch(32'h0000_1080);
        chk("conf_try", {31'd0, bus.try_start_insfetch_task}, 32'd1);
        chk("conf_addr", bus.insfetch_addr, 32'h0000_1080);
        complete(32'hAAAA_0001);
        chk_out("conf_resp", 1'b1, 32'hAAAA_0001, 1'b0);
        fetch(32'h0000_1000);
        chk("conf_remiss", {31'd0, bus.try_start_insfetch_task}, 32'd1);
        complete(32'h0000_0013);

        // Flush mid-miss, done 3 cycles later
        fetch(32'h0000_1004);
        flush_pipline = 1'b1;
        tick();
        flush_pipline = 1'b0;
        tick();
        chk("drain_try", {31'd0, bus.try_start_insfetch_task}, 32'd1);
        tick();
        complete(32'h0000_0055);
        chk_out("drain_done", 1'b0, 32'd0, 1'b0);
        fetch(32'h0000_1004);
        chk_out("drain_hit", 1'b1, 32'h0000_0055, 1'b0);

        // Freeze during MISS with done pending
        fetch(32'h0000_1008);
        bus.insfetch_task_done = 1'b1;
        bus.insfetch_ins_full  = 32'h0000_0077;
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("frozen", 1'b0, 32'd0, 1'b1);
        end
        rdy_in = 1'b1;
        tick();
        bus.insfetch_task_done = 1'b0;
        chk_out("unfrozen", 1'b1, 32'h0000_0077, 1'b0);

        // Flush in IDLE masks a would-be hit
        flush_pipline = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_1000;
        #1;
        chk("flush_mask_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        flush_pipline = 1'b0;
        bus.req_valid = 1'b0;
        chk_out("flush_idle", 1'b0, 32'd0, 1'b0);

        // Flush together with done
        fetch(32'h0000_100C);
        flush_pipline = 1'b1;
        complete(32'h0000_0099);
        flush_pipline = 1'b0;
        chk_out("flush_done", 1'b0, 32'd0, 1'b0);
        fetch(32'h0000_100C);
        chk_out("flush_done_hit", 1'b1, 32'h0000_0099, 1'b0);

        // Done with no task outstanding is ignored
        complete(32'hDEAD_BEEF);
        chk_out("stray_done", 1'b0, 32'd0, 1'b0);
        fetch(32'h0000_1000);
        chk_out("stray_hit", 1'b1, 32'h0000_0013, 1'b0);

        // Invalidate all
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        fetch(32'h0000_1000);
        chk("inv_miss", {31'd0, bus.try_start_insfetch_task}, 32'd1);
        complete(32'h0000_0013);

        // Invalidate in the same cycle as a fill
        fetch(32'h0000_1010);
        inv_all = 1'b1;
        complete(32'h0000_0042);
        inv_all = 1'b0;
        chk_out("inv_fill_resp", 1'b1, 32'h0000_0042, 1'b0);
        fetch(32'h0000_1010);
        chk("inv_fill_remiss", {31'd0, bus.try_start_insfetch_task}, 32'd1);
        complete(32'h0000_0042);

        // Asynchronous reset in the middle of a miss
        fetch(32'h0000_1014);
        chk("prereset_try", {31'd0, bus.try_start_insfetch_task}, 32'd1);
        #1 rst_in = 1'b0;
        #1;
        chk("areset_try", {31'd0, bus.try_start_insfetch_task}, 32'd0);
        chk("areset_addr", bus.insfetch_addr, 32'd0);
        chk("areset_rv", {31'd0, bus.resp_valid}, 32'd0);
        chk("areset_ins", bus.resp_ins, 32'd0);
        chk("areset_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        rst_in = 1'b1;
        tick();
        fetch(32'h0000_1000);
        chk("post_reset_miss", {31'd0, bus.try_start_insfetch_task}, 32'd1);
        chk("post_reset_addr", bus.insfetch_addr, 32'h0000_1000);
        complete(32'h0000_0013);
        chk_out("post_reset_resp", 1'b1, 32'h0000_0013, 1'b0);
        tick();

`ifdef ICACHE_STATS_EN
        chk("stat_hits", stat_hits, m_hits);
        chk("stat_misses", stat_misses, m_misses);
        chk("stat_misses_lit", stat_misses, 32'd1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
